// File: rtl/synth_seq_pkg.sv
// Shared types and default sizing for the note step sequencer.
package synth_seq_pkg;
  localparam int DEF_FREQ_W  = 24;
  localparam int DEF_STEPS   = 8;
  localparam int DEF_TEMPO_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } seq_state_e;
endpackage

// File: rtl/seq_pattern_ram.sv
// Pattern store: STEPS entries of {gate, freq}, registered read with
// write-first forwarding so a same-cycle write is what gets played.
module seq_pattern_ram
  import synth_seq_pkg::*;
#(
  parameter int STEPS  = DEF_STEPS,
  parameter int STEP_W = 3,
  parameter int FREQ_W = DEF_FREQ_W
) (
  input  logic              clk,
  input  logic              system_rst_n,
  input  logic              wr_en_i,
  input  logic [STEP_W-1:0] wr_addr_i,
  input  logic [FREQ_W-1:0] wr_freq_i,
  input  logic              wr_gate_i,
  input  logic              rd_en_i,
  input  logic [STEP_W-1:0] rd_addr_i,
  output logic [FREQ_W-1:0] rd_freq_o,
  output logic              rd_gate_o
);
  logic [STEPS-1:0][FREQ_W:0] mem_q;
  logic [FREQ_W:0]            rd_q;

  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      mem_q <= '0;
      rd_q  <= '0;
    end else begin
      if (wr_en_i) mem_q[wr_addr_i] <= {wr_gate_i, wr_freq_i};
      if (rd_en_i)
        rd_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? {wr_gate_i, wr_freq_i}
                                                      : mem_q[rd_addr_i];
    end
  end

  assign rd_freq_o = rd_q[FREQ_W-1:0];
  assign rd_gate_o = rd_q[FREQ_W];
endmodule

// File: rtl/note_step_sequencer.sv
// Step sequencer: IDLE/LOAD/PLAY FSM, tick counter and optional glide slew.
// Define SEQ_GLIDE_EN to add the glide_rate input and portamento between steps.
module note_step_sequencer
  import synth_seq_pkg::*;
#(
  parameter int STEPS   = DEF_STEPS,
  parameter int STEP_W  = 3,
  parameter int TEMPO_W = DEF_TEMPO_W,
  parameter int FREQ_W  = DEF_FREQ_W
) (
  input  logic               clk,
  input  logic               system_rst_n,
  input  logic               wr_en,
  input  logic [STEP_W-1:0]  wr_addr,
  input  logic [FREQ_W-1:0]  wr_freq,
  input  logic               wr_gate,
  input  logic               run,
  input  logic [TEMPO_W-1:0] step_len,
  input  logic [TEMPO_W-1:0] gate_len,
  input  logic [STEP_W-1:0]  last_step,
`ifdef SEQ_GLIDE_EN
  input  logic [FREQ_W-1:0]  glide_rate,
`endif
  output logic [FREQ_W-1:0]  freq_out,
  output logic               gate_out,
  output logic [STEP_W-1:0]  step_idx,
  output logic               step_pulse
);
  seq_state_e         state_q, state_d;
  logic [STEP_W-1:0]  step_idx_q, step_idx_d;
  logic [TEMPO_W-1:0] tick_q, tick_d;
  logic [FREQ_W-1:0]  ent_freq;
  logic               ent_gate;

  seq_pattern_ram #(.STEPS(STEPS), .STEP_W(STEP_W), .FREQ_W(FREQ_W)) u_ram (
    .clk          (clk),
    .system_rst_n (system_rst_n),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_freq_i    (wr_freq),
    .wr_gate_i    (wr_gate),
    .rd_en_i      (state_q == LOAD),
    .rd_addr_i    (step_idx_q),
    .rd_freq_o    (ent_freq),
    .rd_gate_o    (ent_gate)
  );

  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state_q    <= IDLE;
      step_idx_q <= '0;
      tick_q     <= '0;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    tick_d     = tick_q;
    case (state_q)
      IDLE: begin
        step_idx_d = '0;
        tick_d     = '0;
        if (run) state_d = LOAD;
      end
      LOAD: begin
        tick_d  = '0;
        state_d = PLAY;
      end
      PLAY: begin
        tick_d = tick_q + 1'b1;
        // >= keeps a shortened step_len from running the counter to wrap
        if (tick_q >= step_len) begin
          state_d    = LOAD;
          step_idx_d = (step_idx_q >= last_step) ? '0 : step_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!run) begin
      state_d    = IDLE;
      step_idx_d = '0;
      tick_d     = '0;
    end
  end

  assign gate_out   = (state_q == PLAY) && ent_gate && (tick_q < gate_len);
  assign step_pulse = (state_q == PLAY) && (tick_q == '0);
  assign step_idx   = step_idx_q;

`ifdef SEQ_GLIDE_EN
  logic [FREQ_W-1:0] freq_q, freq_glide;
  logic              jump_q;

  function automatic logic [FREQ_W-1:0] slew(input logic [FREQ_W-1:0] cur,
                                             input logic [FREQ_W-1:0] tgt,
                                             input logic [FREQ_W-1:0] rate);
    if (cur < tgt) return ((tgt - cur) <= rate) ? tgt : cur + rate;
    else           return ((cur - tgt) <= rate) ? tgt : cur - rate;
  endfunction

  assign freq_glide = (jump_q || (glide_rate == '0)) ? ent_freq
                                                     : slew(freq_q, ent_freq, glide_rate);
  assign freq_out   = (state_q == PLAY) ? freq_glide : freq_q;

  // jump_q marks the first step after IDLE, which never glides
  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      freq_q <= '0;
      jump_q <= 1'b1;
    end else begin
      if (state_q == PLAY) freq_q <= freq_glide;
      if (state_q == IDLE)      jump_q <= 1'b1;
      else if (state_q == PLAY) jump_q <= 1'b0;
    end
  end
`else
  assign freq_out = ent_freq;
`endif
endmodule

// File: doc/note_step_sequencer.md
# note_step_sequencer

Autonomous step sequencer that plays a small note pattern into the oscillator datapath. It sits between the SPI register decode and the phase accumulator. It holds an 8-entry pattern of 24-bit frequency words plus gate flags, and steps through the pattern at a programmable tempo. On each step it drives the frequency word, the gate, and a step strobe; the top level ORs the gate with the hardware gate pin.

## Interface
Parameters:
- STEPS, 8: number of pattern entries (power of two)
- STEP_W, 3: log2(STEPS)
- TEMPO_W, 20: width of the tempo and gate-length counters
- FREQ_W, 24: width of the frequency word

Ports:
- clk  in  1  system clock
- system_rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  pattern write strobe (one entry per cycle)
- wr_addr  in  STEP_W  pattern entry to write
- wr_freq  in  FREQ_W  frequency word for the entry
- wr_gate  in  1  gate flag for the entry (0 = rest)
- run  in  1  level enable; 1 = play, 0 = stop
- step_len  in  TEMPO_W  PLAY cycles per step minus 1
- gate_len  in  TEMPO_W  PLAY cycles with gate high, per step
- last_step  in  STEP_W  index of the final step before wrap to 0
- freq_out  out  FREQ_W  frequency word to the phase accumulator
- gate_out  out  1  sequencer gate
- step_idx  out  STEP_W  index of the step currently playing
- step_pulse  out  1  one-cycle strobe on the first PLAY cycle of each step

## Operation
- Pattern storage: flop array, STEPS × (FREQ_W+1), cleared to 0 on reset. Reads are registered.
- FSM states:
  - IDLE: run=0. gate_out=0, step_idx=0, freq_out holds its last value.
  - LOAD: one cycle. Reads pattern[step_idx]; gate_out=0; tick counter cleared.
  - PLAY: the step sounds. tick counter increments each cycle.
- Transitions:
  - IDLE→LOAD when run=1.
  - LOAD→PLAY always. freq_out ← entry freq. step_pulse=1 on the first PLAY cycle.
  - PLAY→LOAD when tick==step_len. step_idx ← (step_idx==last_step) ? 0 : step_idx+1.
  - Any state→IDLE when run=0. The next cycle has gate_out=0 and step_idx=0.
- gate_out in PLAY = entry gate AND (tick < gate_len).
  - gate_len=0 → gate never rises.
  - gate_len>step_len → gate is high for all PLAY cycles.
  - The LOAD cycle always forces a 1-cycle low gap, which guarantees a retrigger.
- Writes:
  - A write to any entry is accepted in any state.
  - A write in the same cycle as a LOAD read of the same address is forwarded: the new data is played.
  - A write to the currently playing entry does not change freq_out/gate_out until that entry is next loaded.
- Changes to last_step take effect at the next step boundary. If step_idx>last_step at that boundary, the index wraps to 0.

## Timing
- Reset values: freq_out=0, gate_out=0, step_idx=0, step_pulse=0, FSM=IDLE.
- run rises at cycle N → LOAD at N+1 → freq_out, step_pulse, and gate_out are valid at N+2.
- Step period is exactly step_len+2 cycles (1 LOAD + step_len+1 PLAY). Minimum period is 2 cycles, at step_len=0.
- run falling → gate_out=0 one cycle later. The tick counter is discarded.
- Reset asserted mid-step → every output returns to its reset value immediately (asynchronous reset). The pattern is cleared.

## Configuration
- SEQ_GLIDE_EN defined:
  - Adds input glide_rate [FREQ_W-1:0].
  - On LOAD→PLAY the entry freq becomes the target. freq_out does not jump.
  - In each PLAY cycle freq_out moves toward the target by glide_rate and clamps exactly at the target (no overshoot).
  - glide_rate=0 → immediate jump.
  - The first step after IDLE always jumps.
- SEQ_GLIDE_EN undefined: the glide_rate port is absent and freq_out jumps at step start.

## Structure
- Package synth_seq_pkg holds:
  - the FSM state enum (IDLE/LOAD/PLAY)
  - default constants: FREQ_W=24, STEPS=8, TEMPO_W=20
- Sub-module seq_pattern_ram: flop array, single write port, registered read with write-first forwarding.
- The FSM, tick counter, and glide slew live in the top module.

## Test plan
- Reset with run=1 held → all outputs 0. After release, step 0 plays freq 0 with gate 0.
- Write entries 0..3 = 0x001000/0x002000/0x003000/0x004000, all gates=1. Set last_step=3, step_len=9, gate_len=5 → step period 11 cycles. gate high 5 cycles per step. Sequence wraps 3→0. step_pulse fires once every 11 cycles.
- Set entry 2 gate=0 → no gate during step 2. freq_out still shows 0x003000.
- Drop run mid-PLAY of step 2 → gate_out=0 and step_idx=0 the next cycle. Raise run again → step 0 restarts with a 2-cycle latency.
- Write entry 1 = 0x00ABCD in the same cycle entry 1 is in LOAD → freq_out=0x00ABCD at that step's step_pulse.
- SEQ_GLIDE_EN, glide_rate=0x000800, step from 0x001000 to 0x002000 → freq_out reaches 0x002000 after 2 PLAY cycles (0x001800, 0x002000) and holds with no overshoot.
